// File: rtl/btb_pkg.sv
// Shared widths, entry/request structs and FSM encoding for the BTB update path.
package btb_pkg;
    localparam int SETS   = 8;
    localparam int IDX_W  = $clog2(SETS);
    localparam int ADDR_W = 32;
    localparam int TAG_W  = ADDR_W - IDX_W - 2;

    localparam logic [1:0] CTR_INIT = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [1:0]        ctr;
    } btb_entry_t;

    typedef struct packed {
        logic [IDX_W-1:0]  index;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic              taken;
    } upd_req_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WRITE  = 2'd2
    } state_t;

    // Two-bit saturating direction counter.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != 2'b11) begin
            res = ctr + 2'b01;
        end else if (!taken && ctr != 2'b00) begin
            res = ctr - 2'b01;
        end
        return res;
    endfunction
endpackage

// File: rtl/btb_upd_fifo.sv
// Small queue of pending BTB updates; head is visible combinationally, pop takes effect at the clock edge.
// Pushes while full are ignored; the producer is expected to honour o_full.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_push,
    input  upd_req_t i_push_dat,
    input  logic     i_pop,
    output upd_req_t o_head_dat,
    output logic     o_full,
    output logic     o_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    upd_req_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_head_dat = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end
endmodule

// File: rtl/btb_update.sv
// BTB write side: queues resolved branches, then LOOKUP/WRITE against the 2-way entry arrays; IF read port is combinational.
// Latency accept->visible 4 cycles; upd_ready drops only when the queue is full, 1 update per 2 cycles sustained.
module btb_update
    import btb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        upd_valid,
    output logic                        upd_ready,
    input  logic [ADDR_W-1:0]           upd_pc,
    input  logic [ADDR_W-1:0]           upd_target,
    input  logic                        upd_taken,
    input  logic [IDX_W-1:0]            rd_index,
    output logic [1:0]                  rd_valid,
    output logic [1:0][TAG_W-1:0]       rd_tag,
    output logic [1:0][ADDR_W-1:0]      rd_target,
    output logic [1:0]                  rd_pred_taken,
    output logic [IDX_W-1:0]            update_index,
    input  logic                        lru_write_bit,
    output logic                        new_entry,
    output logic                        busy
);
    state_t     r_state;
    state_t     w_state_nxt;
    upd_req_t   r_req;
    btb_entry_t r_way0 [SETS];
    btb_entry_t r_way1 [SETS];

    logic       r_wr_en;
    logic       r_wr_way;
    logic       r_alloc;
    btb_entry_t r_wr_entry;
    logic       w_wr_en;
    logic       w_wr_way;
    logic       w_alloc;
    btb_entry_t w_wr_entry;

    upd_req_t   w_push_dat;
    upd_req_t   w_head;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    btb_entry_t w_e0;
    btb_entry_t w_e1;
    logic       w_hit0;
    logic       w_hit1;
    logic       w_unused;

    assign w_unused   = ^upd_pc[1:0];
    assign upd_ready  = !w_full;
    assign w_push     = upd_valid && upd_ready;
    assign w_push_dat = '{index:  upd_pc[IDX_W+1:2],
                          tag:    upd_pc[ADDR_W-1:IDX_W+2],
                          target: upd_target,
                          taken:  upd_taken};

    btb_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign w_e0   = r_way0[r_req.index];
    assign w_e1   = r_way1[r_req.index];
    assign w_hit0 = w_e0.valid && (w_e0.tag == r_req.tag);
    assign w_hit1 = w_e1.valid && (w_e1.tag == r_req.tag);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_way    = 1'b0;
        w_alloc     = 1'b0;
        w_wr_entry  = '0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                w_state_nxt = WRITE;
                if (w_hit0 || w_hit1) begin
                    w_wr_en        = 1'b1;
                    w_wr_way       = !w_hit0;
                    w_wr_entry     = w_hit0 ? w_e0 : w_e1;
                    w_wr_entry.ctr = ctr_next(w_wr_entry.ctr, r_req.taken);
                    if (r_req.taken) begin
                        w_wr_entry.target = r_req.target;
                    end
                end else if (r_req.taken) begin
                    // Fill an empty way first; otherwise evict the less recently used one.
                    w_wr_en    = 1'b1;
                    w_alloc    = 1'b1;
                    w_wr_way   = !w_e0.valid ? 1'b0 : (!w_e1.valid ? 1'b1 : !lru_write_bit);
                    w_wr_entry = '{valid: 1'b1, tag: r_req.tag, target: r_req.target, ctr: CTR_INIT};
                end
            end
            WRITE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = LOOKUP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_req      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_way   <= 1'b0;
            r_alloc    <= 1'b0;
            r_wr_entry <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_req <= w_head;
            end
            if (r_state == LOOKUP) begin
                r_wr_en    <= w_wr_en;
                r_wr_way   <= w_wr_way;
                r_alloc    <= w_alloc;
                r_wr_entry <= w_wr_entry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                r_way0[s] <= '0;
                r_way1[s] <= '0;
            end
        end else if (r_state == WRITE && r_wr_en) begin
            if (r_wr_way) begin
                r_way1[r_req.index] <= r_wr_entry;
            end else begin
                r_way0[r_req.index] <= r_wr_entry;
            end
        end
    end

    assign update_index = r_req.index;
    assign new_entry    = (r_state == WRITE) && r_alloc;
    assign busy         = (r_state != IDLE) || !w_empty;

    // No write bypass: a commit shows up here the cycle after WRITE.
    assign rd_valid      = {r_way1[rd_index].valid,  r_way0[rd_index].valid};
    assign rd_tag        = {r_way1[rd_index].tag,    r_way0[rd_index].tag};
    assign rd_target     = {r_way1[rd_index].target, r_way0[rd_index].target};
    assign rd_pred_taken = {r_way1[rd_index].ctr[1], r_way0[rd_index].ctr[1]};
endmodule

// File: tb/tb_btb_update.sv
// Directed bench for btb_update: allocation, counter saturation, LRU victim choice, queue backpressure, mid-flight reset.
module tb_btb_update;
    import btb_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   upd_valid;
    logic                   upd_ready;
    logic [ADDR_W-1:0]      upd_pc;
    logic [ADDR_W-1:0]      upd_target;
    logic                   upd_taken;
    logic [IDX_W-1:0]       rd_index;
    logic [1:0]             rd_valid;
    logic [1:0][TAG_W-1:0]  rd_tag;
    logic [1:0][ADDR_W-1:0] rd_target;
    logic [1:0]             rd_pred_taken;
    logic [IDX_W-1:0]       update_index;
    logic                   lru_write_bit;
    logic                   new_entry;
    logic                   busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    btb_update #(.FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_pc        (upd_pc),
        .upd_target    (upd_target),
        .upd_taken     (upd_taken),
        .rd_index      (rd_index),
        .rd_valid      (rd_valid),
        .rd_tag        (rd_tag),
        .rd_target     (rd_target),
        .rd_pred_taken (rd_pred_taken),
        .update_index  (update_index),
        .lru_write_bit (lru_write_bit),
        .new_entry     (new_entry),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated update: accept, pop, LOOKUP (LRU bit driven only here), WRITE, then idle with result visible.
    task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                             input logic lru, input logic exp_new, input logic [2:0] exp_idx);
        @(negedge clk);
        chk("ready_before", 64'(upd_ready), 64'd1);
        upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk;
        @(negedge clk);
        upd_valid = 1'b0;
        chk("busy_queued", 64'(busy), 64'd1);
        @(negedge clk);
        chk("update_index", 64'(update_index), 64'(exp_idx));
        lru_write_bit = lru;
        @(negedge clk);
        chk("new_entry_write", 64'(new_entry), 64'(exp_new));
        chk("update_index_hold", 64'(update_index), 64'(exp_idx));
        lru_write_bit = ~lru;
        @(negedge clk);
        chk("busy_done", 64'(busy), 64'd0);
        chk("new_entry_off", 64'(new_entry), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
        rd_index = 3'd4; lru_write_bit = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(upd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_new_entry", 64'(new_entry), 64'd0);
        chk("rst_update_index", 64'(update_index), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        rst_n = 1'b1;

        // Allocation into set 4, tag 0.
        do_update(32'h10, 32'h100, 1'b1, 1'b1, 1'b1, 3'd4);
        chk("alloc_valid", 64'(rd_valid), 64'b01);
        chk("alloc_target", 64'(rd_target[0]), 64'h100);
        chk("alloc_tag", 64'(rd_tag[0]), 64'h0);
        chk("alloc_pred", 64'(rd_pred_taken), 64'b01);

        // Counter 2->1->0->0 with not-taken (target untouched), then 0->1->2->3, then 3->2.
        do_update(32'h10, 32'hDEAD, 1'b0, 1'b1, 1'b0, 3'd4);
        chk("nt1_pred", 64'(rd_pred_taken[0]), 64'd0);
        chk("nt1_target", 64'(rd_target[0]), 64'h100);
        do_update(32'h10, 32'hDEAD, 1'b0, 1'b1, 1'b0, 3'd4);
        chk("nt2_pred", 64'(rd_pred_taken[0]), 64'd0);
        do_update(32'h10, 32'hDEAD, 1'b0, 1'b1, 1'b0, 3'd4);
        chk("nt3_pred", 64'(rd_pred_taken[0]), 64'd0);
        do_update(32'h10, 32'h200, 1'b1, 1'b1, 1'b0, 3'd4);
        chk("t1_pred_from0", 64'(rd_pred_taken[0]), 64'd0);
        chk("t1_target", 64'(rd_target[0]), 64'h200);
        do_update(32'h10, 32'h200, 1'b1, 1'b1, 1'b0, 3'd4);
        chk("t2_pred", 64'(rd_pred_taken[0]), 64'd1);
        do_update(32'h10, 32'h200, 1'b1, 1'b1, 1'b0, 3'd4);
        do_update(32'h10, 32'h200, 1'b0, 1'b1, 1'b0, 3'd4);
        chk("sat3_nt_pred", 64'(rd_pred_taken[0]), 64'd1);
        chk("hit_valid", 64'(rd_valid), 64'b01);

        // Second tag fills way1; then LRU-driven replacement.
        do_update(32'h30, 32'h300, 1'b1, 1'b1, 1'b1, 3'd4);
        chk("fill_valid", 64'(rd_valid), 64'b11);
        chk("fill_tag1", 64'(rd_tag[1]), 64'h1);
        chk("fill_target1", 64'(rd_target[1]), 64'h300);
        do_update(32'h50, 32'h500, 1'b1, 1'b0, 1'b1, 3'd4);
        chk("lru0_tag1", 64'(rd_tag[1]), 64'h2);
        chk("lru0_target1", 64'(rd_target[1]), 64'h500);
        chk("lru0_tag0", 64'(rd_tag[0]), 64'h0);
        chk("lru0_pred1", 64'(rd_pred_taken[1]), 64'd1);
        do_update(32'h70, 32'h700, 1'b1, 1'b1, 1'b1, 3'd4);
        chk("lru1_tag0", 64'(rd_tag[0]), 64'h3);
        chk("lru1_target0", 64'(rd_target[0]), 64'h700);
        chk("lru1_tag1", 64'(rd_tag[1]), 64'h2);

        // Not-taken miss on an empty set.
        rd_index = 3'd1;
        do_update(32'h4, 32'h400, 1'b0, 1'b1, 1'b0, 3'd1);
        chk("ntmiss_valid", 64'(rd_valid), 64'd0);

        // Three back-to-back updates to set 2 with valid held high.
        rd_index = 3'd2;
        @(negedge clk);
        upd_valid = 1'b1; upd_taken = 1'b1; upd_pc = 32'h08; upd_target = 32'hA00;
        @(negedge clk);
        chk("b2b_ready_1", 64'(upd_ready), 64'd1);
        upd_pc = 32'h28; upd_target = 32'hB00;
        @(negedge clk);
        chk("b2b_ready_2", 64'(upd_ready), 64'd1);
        chk("b2b_lookup_a", 64'(update_index), 64'd2);
        upd_pc = 32'h48; upd_target = 32'hC00;
        @(negedge clk);
        chk("b2b_ready_full", 64'(upd_ready), 64'd0);
        chk("b2b_new_a", 64'(new_entry), 64'd1);
        upd_valid = 1'b0;
        @(negedge clk);
        chk("b2b_ready_back", 64'(upd_ready), 64'd1);
        chk("b2b_new_off", 64'(new_entry), 64'd0);
        chk("b2b_a_valid", 64'(rd_valid), 64'b01);
        chk("b2b_a_target", 64'(rd_target[0]), 64'hA00);
        @(negedge clk);
        chk("b2b_new_b", 64'(new_entry), 64'd1);
        chk("b2b_busy_b", 64'(busy), 64'd1);
        @(negedge clk);
        chk("b2b_b_valid", 64'(rd_valid), 64'b11);
        chk("b2b_b_tag", 64'(rd_tag[1]), 64'h1);
        lru_write_bit = 1'b0;
        @(negedge clk);
        chk("b2b_new_c", 64'(new_entry), 64'd1);
        chk("b2b_busy_c", 64'(busy), 64'd1);
        lru_write_bit = 1'b1;
        @(negedge clk);
        chk("b2b_busy_end", 64'(busy), 64'd0);
        chk("b2b_c_tag1", 64'(rd_tag[1]), 64'h2);
        chk("b2b_c_target1", 64'(rd_target[1]), 64'hC00);
        chk("b2b_a_tag0", 64'(rd_tag[0]), 64'h0);

        // Reset during LOOKUP with one entry still queued.
        rd_index = 3'd6;
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'h18; upd_target = 32'hD00;
        @(negedge clk);
        upd_pc = 32'h38; upd_target = 32'hE00;
        @(negedge clk);
        upd_valid = 1'b0;
        chk("mid_lookup_idx", 64'(update_index), 64'd6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(upd_ready), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_new", 64'(new_entry), 64'd0);
        chk("mid_rst_idx", 64'(update_index), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_valid6", 64'(rd_valid), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_ready", 64'(upd_ready), 64'd1);
        rd_index = 3'd4;
        #1;
        chk("post_rst_valid4", 64'(rd_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
